// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequences one kernel-load + execute pass over a row x col
// MAC tile array. It pops vectors from the L0 buffer and issues a per-row
// instruction stream, skewed by one cycle per row. It then waits for the
// array pipeline to drain and pulses done.
//
// Handshake: l0_rd is a pop strobe. It is asserted only in LOAD or EXEC while
// l0_empty is low, and the vector is consumed on that same clock edge. The
// matching instruction appears on inst_w[1:0] in the following cycle, in
// step with the L0 data. While l0_empty is high, nothing is popped and a
// 00 bubble is issued.
module mac_array_ctrl #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int len_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              os_mode,
    input  logic [len_bw-1:0] exec_len,
    input  logic              l0_empty,
    output logic              l0_rd,
    output logic [2*row-1:0]  inst_w,
    output logic              mode_select,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    localparam int DRAIN_CYC = row + col - 1;
    localparam int LEN_MAX   = (1 << len_bw) - 1;
    localparam int MAX_A     = (col > LEN_MAX) ? col : LEN_MAX;
    localparam int CNT_MAX   = (MAX_A > DRAIN_CYC) ? MAX_A : DRAIN_CYC;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic              os_q;
    logic [len_bw-1:0] len_q;
    logic [1:0]        skew_q [row];

    logic issue;
    logic last_load;
    logic last_exec;
    logic last_drain;

    assign issue      = ((state == S_LOAD) || (state == S_EXEC)) && !l0_empty;
    assign last_load  = (cnt == CW'(col - 1));
    assign last_exec  = (cnt == (CW'(len_q) - CW'(1)));
    assign last_drain = (cnt == CW'(DRAIN_CYC - 1));

    // Pass sequencing: the state, the issue/drain counter, and the config latched at start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            os_q  <= 1'b0;
            len_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        os_q  <= os_mode;
                        len_q <= exec_len;
                        cnt   <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (issue) begin
                        if (last_load) begin
                            cnt   <= '0;
                            state <= (len_q != '0) ? S_EXEC : S_DRAIN;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_EXEC: begin
                    if (issue) begin
                        if (last_exec) begin
                            cnt   <= '0;
                            state <= S_DRAIN;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_drain) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Instruction skew chain: entry 0 is the base instruction, and each later row is the previous row one cycle late.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < row; r++) begin
                skew_q[r] <= 2'b00;
            end
        end else begin
            if (issue) begin
                skew_q[0] <= (state == S_LOAD) ? 2'b01 : 2'b10;
            end else begin
                skew_q[0] <= 2'b00;
            end
            for (int r = 1; r < row; r++) begin
                skew_q[r] <= skew_q[r-1];
            end
        end
    end

    // Flatten the skew chain onto inst_w, forced to zero while reset is held.
    always_comb begin
        inst_w = '0;
        if (!reset) begin
            for (int r = 0; r < row; r++) begin
                inst_w[2*r +: 2] = skew_q[r];
            end
        end
    end

    assign l0_rd       = issue && !reset;
    assign busy        = (state != S_IDLE) && !reset;
    assign done        = (state == S_DONE) && !reset;
    assign mode_select = busy && os_q;
    assign state_dbg   = state;

endmodule
